// File: rtl/ld_counter_seq_pkg.sv
// Shared definitions for the loadable counter sequencer: state encodings,
// MODE constants and the preload computation.
package ld_counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam int unsigned MAX_W = 64;

  // Two's complement of PERIOD; callers truncate to their own width, which
  // yields 2^WIDTH - PERIOD modulo 2^WIDTH.
  function automatic logic [MAX_W-1:0] preload(input logic [MAX_W-1:0] period);
    return (~period) + MAX_W'(1);
  endfunction

endpackage

// File: rtl/ld_counter_slice.sv
// WIDTH-bit loadable up-counter built as a cascade of 4-bit slices with a
// ripple carry chain; load has priority over counting.
module ld_counter_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ce,
  input  logic             ci,
  output logic [WIDTH-1:0] q,
  output logic             co
);

  localparam int unsigned NIB = WIDTH / 4;

  logic [NIB:0] carry;

  assign carry[0] = ci & ce;

  for (genvar i = 0; i < NIB; i++) begin : g_nib
    logic [3:0] cnt;

    assign carry[i+1]  = carry[i] & (cnt == 4'hF);
    assign q[4*i +: 4] = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (load) begin
        cnt <= din[4*i +: 4];
      end else if (carry[i]) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign co = carry[NIB];

endmodule

// File: rtl/ld_counter_seq.sv
// Sequencer for the nibble-cascade counter: converts PERIOD to a preload,
// runs one-shot or auto-reload, flags terminal count and illegal starts.
// Optional TICK prescaler is built when CNT_SEQ_PRESCALE_EN is defined.
module ld_counter_seq
  import ld_counter_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter     GSR   = "ENABLED",
  parameter int PRESC = 4
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             STOP,
  input  logic             MODE,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic             TICK,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  state_t           state;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] preload_val;
  logic             mode_q;
  logic             rst_n;
  logic             eff_tick;
  logic             load;
  logic [WIDTH-1:0] load_data;

  // The global set/reset net lives in the flop primitives; at RTL both GSR
  // settings reset from RSTN. Illegal parameter values leave rst_n undriven.
  if ((GSR == "ENABLED" || GSR == "DISABLED") && PRESC >= 1 && PRESC <= 256) begin : g_rst
    assign rst_n = RSTN;
  end

  assign preload_val = WIDTH'(preload(MAX_W'(period_q)));

`ifdef CNT_SEQ_PRESCALE_EN
  localparam int unsigned DIV_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESC - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (state != RUN || STOP) begin
      div <= '0;
    end else if (TICK) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign eff_tick = TICK & (div == DIV_LAST);
`else
  assign eff_tick = TICK;
`endif

  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (PERIOD != '0) begin
              period_q <= PERIOD;
              mode_q   <= MODE;
              state    <= LOAD;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        LOAD: state <= STOP ? IDLE : RUN;
        RUN: begin
          if (STOP) begin
            state <= IDLE;
          end else if (CO) begin
            DONE <= 1'b1;
            if (mode_q != MODE_RELOAD) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Every exit to IDLE clears Q through a load of zero; reload reuses L.
  always_comb begin
    load      = 1'b0;
    load_data = preload_val;
    case (state)
      LOAD: begin
        load      = 1'b1;
        load_data = STOP ? '0 : preload_val;
      end
      RUN: begin
        if (STOP) begin
          load      = 1'b1;
          load_data = '0;
        end else if (CO) begin
          load      = 1'b1;
          load_data = (mode_q == MODE_RELOAD) ? preload_val : '0;
        end
      end
      default: ;
    endcase
  end

  assign BUSY = (state == LOAD) || (state == RUN);

  ld_counter_slice #(.WIDTH(WIDTH)) u_slice (
    .clk   (CK),
    .rst_n (rst_n),
    .load  (load),
    .din   (load_data),
    .ce    (state == RUN),
    .ci    (eff_tick),
    .q     (Q),
    .co    (CO)
  );

endmodule

// File: tb/tb_ld_counter_seq.sv
// Self-checking bench for ld_counter_seq: vector table plus multi-cycle
// sequences (reload cadence, TICK gating, latency, async reset).
module tb_ld_counter_seq;

  localparam int W        = 8;
  localparam int PRESC_TB = 4;
`ifdef CNT_SEQ_PRESCALE_EN
  localparam int EFF = PRESC_TB;
`else
  localparam int EFF = 1;
`endif

  logic         CK = 1'b0;
  logic         RSTN = 1'b0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic         MODE = 1'b0;
  logic [W-1:0] PERIOD = '0;
  logic         TICK = 1'b0;
  logic [W-1:0] Q;
  logic         CO, BUSY, DONE, ERR;

  int checks = 0;
  int errors = 0;

  always #5 CK = ~CK;

  ld_counter_seq #(.WIDTH(W), .GSR("ENABLED"), .PRESC(PRESC_TB)) dut (
    .CK(CK), .RSTN(RSTN), .START(START), .STOP(STOP), .MODE(MODE),
    .PERIOD(PERIOD), .TICK(TICK), .Q(Q), .CO(CO), .BUSY(BUSY),
    .DONE(DONE), .ERR(ERR)
  );

  typedef struct {
    logic         start, stop, mode;
    logic [W-1:0] period;
    logic         tick;
    logic         co;
    logic [W-1:0] q;
    logic         busy, done, err;
  } vec_t;

  vec_t vecs[20];
  vec_t sb[$];

  function automatic vec_t mk(input logic st, sp, m, input logic [W-1:0] p,
                              input logic t, c, input logic [W-1:0] q,
                              input logic b, d, e);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = m; v.period = p; v.tick = t;
    v.co = c; v.q = q; v.busy = b; v.done = d; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, sp, m, input logic [W-1:0] p, input logic t);
    @(negedge CK);
    START = st; STOP = sp; MODE = m; PERIOD = p; TICK = t;
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    drive(v.start, v.stop, v.mode, v.period, v.tick);
    sb.push_back(v);
    #1 check($sformatf("v%0d_co", idx), 32'(CO), 32'(v.co));
    @(posedge CK); #1;
    e = sb.pop_front();
    check($sformatf("v%0d_q", idx),    32'(Q),    32'(e.q));
    check($sformatf("v%0d_busy", idx), 32'(BUSY), 32'(e.busy));
    check($sformatf("v%0d_done", idx), 32'(DONE), 32'(e.done));
    check($sformatf("v%0d_err", idx),  32'(ERR),  32'(e.err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t e;
    int   ndone, last, lat, n;
    logic [W-1:0] per_in;

    #1;
    check("rst_q",    32'(Q),    32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_done", 32'(DONE), 32'h0);
    check("rst_err",  32'(ERR),  32'h0);
    check("rst_co",   32'(CO),   32'h0);
    repeat (2) @(negedge CK);
    RSTN = 1'b1;

`ifndef CNT_SEQ_PRESCALE_EN
    //              st sp m  period tk co q      bsy dn er
    vecs[0]  = mk(1, 0, 0, 8'd3, 1, 0, 8'h00, 1, 0, 0);
    vecs[1]  = mk(0, 0, 0, 8'd3, 1, 0, 8'hFD, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 8'd3, 1, 0, 8'hFE, 1, 0, 0);
    vecs[3]  = mk(0, 0, 0, 8'd3, 1, 0, 8'hFF, 1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 8'd3, 1, 1, 8'h00, 0, 1, 0);
    vecs[5]  = mk(0, 0, 0, 8'd3, 1, 0, 8'h00, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0, 8'd0, 1, 0, 8'h00, 0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 8'd0, 1, 0, 8'h00, 0, 0, 0);
    vecs[8]  = mk(1, 1, 0, 8'd2, 1, 0, 8'h00, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 8'd2, 1, 0, 8'hFE, 1, 0, 0);
    vecs[10] = mk(1, 0, 0, 8'd0, 0, 0, 8'hFE, 1, 0, 0);
    vecs[11] = mk(0, 0, 0, 8'd2, 1, 0, 8'hFF, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 8'd2, 1, 1, 8'h00, 0, 1, 0);
    vecs[13] = mk(1, 0, 1, 8'd2, 1, 0, 8'h00, 1, 0, 0);
    vecs[14] = mk(0, 0, 1, 8'd2, 1, 0, 8'hFE, 1, 0, 0);
    vecs[15] = mk(0, 0, 1, 8'd2, 1, 0, 8'hFF, 1, 0, 0);
    vecs[16] = mk(0, 1, 1, 8'd2, 1, 1, 8'h00, 0, 0, 0);
    vecs[17] = mk(1, 0, 0, 8'd4, 1, 0, 8'h00, 1, 0, 0);
    vecs[18] = mk(0, 1, 0, 8'd4, 1, 0, 8'h00, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 8'd4, 0, 0, 8'h00, 0, 0, 0);
    foreach (vecs[i]) apply(vecs[i], i);
`endif

    // Auto-reload, PERIOD = 2: ten periods, Q toggles FE/FF, BUSY held.
    drive(1, 0, 1, 8'd2, 1);
    @(posedge CK); #1;
    ndone = 0;
    for (int c = 1; c <= 1 + 20 * EFF; c++) begin
      drive(0, 0, 1, 8'd2, 1);
      n = (c - 1) / EFF;
      sb.push_back(mk(0, 0, 1, 8'd2, 1, 0, 8'hFE + W'(n % 2), 1,
                      (c > 1) && ((c - 1) % (2 * EFF) == 0), 0));
      @(posedge CK); #1;
      e = sb.pop_front();
      check($sformatf("rl%0d_q", c),    32'(Q),    32'(e.q));
      check($sformatf("rl%0d_done", c), 32'(DONE), 32'(e.done));
      check($sformatf("rl%0d_busy", c), 32'(BUSY), 32'(e.busy));
      if (DONE) ndone++;
    end
    check("rl_done_count", 32'(ndone), 32'd10);
    drive(0, 1, 1, 8'd2, 1);
    @(posedge CK); #1;
    check("rl_stop_busy", 32'(BUSY), 32'h0);
    check("rl_stop_q",    32'(Q),    32'h0);

    // One-shot latency from Q = L to DONE.
    drive(1, 0, 0, 8'd2, 1);
    @(posedge CK); #1;
    drive(0, 0, 0, 8'd2, 1);
    @(posedge CK); #1;
    check("lat_q_l", 32'(Q), 32'hFE);
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      drive(0, 0, 0, 8'd2, 1);
      @(posedge CK); #1;
      if (DONE) begin
        lat = i;
        break;
      end
    end
    check("lat_done", 32'(lat), 32'(2 * EFF));
    check("lat_idle_busy", 32'(BUSY), 32'h0);

    // Auto-reload, PERIOD = 5, TICK toggling; PERIOD input changed mid-run.
    drive(1, 0, 1, 8'd5, 1);
    @(posedge CK); #1;
    per_in = 8'd5;
    ndone  = 0;
    last   = -1;
    for (int cyc = 0; cyc < 60 * EFF; cyc++) begin
      drive(0, 0, 1, per_in, (cyc % 2) == 0);
      @(posedge CK); #1;
      if (DONE) begin
        if (last >= 0) check($sformatf("tg_interval%0d", ndone), 32'(cyc - last), 32'(10 * EFF));
        last = cyc;
        ndone++;
        if (ndone == 2) per_in = 8'd2;
        if (ndone == 4) break;
      end
    end
    check("tg_done_count", 32'(ndone), 32'd4);
    drive(0, 1, 1, 8'd2, 0);
    @(posedge CK); #1;
    check("tg_stop_busy", 32'(BUSY), 32'h0);

    // Asynchronous reset mid-RUN clears outputs without a clock edge.
    drive(1, 0, 0, 8'd5, 1);
    repeat (3) begin
      @(posedge CK); #1;
      drive(0, 0, 0, 8'd5, 1);
    end
    #2;
    check("ar_pre_busy", 32'(BUSY), 32'h1);
    RSTN = 1'b0;
    #1;
    check("ar_q",    32'(Q),    32'h0);
    check("ar_busy", 32'(BUSY), 32'h0);
    check("ar_done", 32'(DONE), 32'h0);
    check("ar_err",  32'(ERR),  32'h0);
    check("ar_co",   32'(CO),   32'h0);
    @(negedge CK);
    RSTN = 1'b1;
    drive(0, 0, 0, 8'd5, 1);
    @(posedge CK); #1;
    check("ar_after_q",    32'(Q),    32'h0);
    check("ar_after_busy", 32'(BUSY), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ld_counter_seq.md
Name: ld_counter_seq

Overview:
- Sequencer for a WIDTH-bit loadable up-counter datapath: the carry-chained nibble counter with load, count enable and terminal carry.
- Converts a requested PERIOD into a preload value and drives load and count-enable.
- Detects terminal count (carry-out), then either reloads (periodic timer) or stops (one-shot).
- Sits between a register/control interface and the counter slice in timer and prescaler subsystems.

Parameters:
- WIDTH, 8: counter width in bits; multiple of 4 (nibble-slice cascade).
- GSR, "ENABLED": "ENABLED" lets the global set/reset net also reset the block; "DISABLED" means RSTN only.
- PRESC, 4: prescale divide ratio, 1..256. Used only when CNT_SEQ_PRESCALE_EN is defined.

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- START  input  1  start request; sampled only in IDLE.
- STOP  input  1  abort request; sampled in LOAD and RUN.
- MODE  input  1  0 = one-shot, 1 = auto-reload; latched on START.
- PERIOD  input  WIDTH  ticks per period; latched on START; 0 is illegal.
- TICK  input  1  count qualifier; the counter advances only on cycles with TICK = 1.
- Q  output  WIDTH  raw counter value.
- CO  output  1  combinational terminal carry: Q all-ones AND effective tick AND state RUN.
- BUSY  output  1  high in LOAD and RUN.
- DONE  output  1  registered one-cycle pulse after each terminal count.
- ERR  output  1  registered one-cycle pulse when START is seen with PERIOD = 0.

Behaviour:
- Reset (RSTN low, asynchronous): state IDLE, Q = 0, BUSY = 0, DONE = 0, ERR = 0, latched PERIOD = 0, MODE = 0, prescaler = 0. All register updates resume on the first rising CK edge after RSTN goes high.
- Preload value: L = 2^WIDTH - PERIOD, computed modulo 2^WIDTH. PERIOD = 1 gives L = all-ones.
- States are IDLE, LOAD, RUN.
- IDLE:
  - START = 1 and PERIOD != 0: latch PERIOD and MODE, go to LOAD.
  - START = 1 and PERIOD = 0: ERR = 1 for one cycle, stay in IDLE.
  - Q holds its value.
- LOAD: lasts one cycle. Q <= L, go to RUN. STOP = 1 instead returns to IDLE with Q <= 0.
- RUN:
  - Effective tick and Q != all-ones: Q <= Q + 1.
  - Effective tick and Q = all-ones (CO = 1): DONE <= 1 on that edge.
    - MODE = 1: Q <= L (latched PERIOD) on the same edge. No idle cycle, stay in RUN.
    - MODE = 0: Q <= 0, go to IDLE.
  - No tick: Q holds.
- Latency: START sampled at edge k, TICK held at 1, gives Q = L after edge k+1 and DONE high after edge k+PERIOD+1. In auto-reload, periods are exactly PERIOD ticks apart.
- STOP in LOAD or RUN: go to IDLE, Q <= 0, no DONE. STOP and CO in the same cycle: STOP wins, DONE stays 0.
- START while BUSY is ignored. PERIOD and MODE changes while BUSY take effect only on the next START.
- START and STOP together in IDLE: START processed, STOP ignored.
- Arithmetic is modulo 2^WIDTH. No saturation.

Optional Feature:
- Macro CNT_SEQ_PRESCALE_EN.
- Defined:
  - An internal divider counts CK cycles where TICK = 1, 0..PRESC-1, then wraps.
  - Effective tick = TICK AND (divider = PRESC-1).
  - Divider clears on LOAD, on STOP and in IDLE.
  - The time to DONE becomes PERIOD*PRESC TICK cycles.
- Undefined: effective tick = TICK. No divider logic exists.

Decomposition:
- Shared package/include ld_counter_seq_pkg holds:
  - state encodings: IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2;
  - MODE constants: MODE_ONESHOT = 0, MODE_RELOAD = 1;
  - preload function computing L from PERIOD and WIDTH.
- One sub-module, ld_counter_slice: WIDTH-bit counter with load, load data, count enable, carry-in and carry-out. This is the nibble-cascade datapath.
- The sequencer FSM, latch registers and optional prescaler stay in ld_counter_seq.

Test Plan:
- WIDTH = 8, PERIOD = 3, MODE = 0, TICK = 1, START at edge 0 -> Q = 0xFD, 0xFE, 0xFF after edges 1-3; DONE = 1 after edge 4; BUSY = 0 and Q = 0 after edge 4.
- PERIOD = 2, MODE = 1, TICK = 1 -> Q alternates 0xFE, 0xFF; DONE pulses every 2 cycles for 10 periods; BUSY stays 1.
- START with PERIOD = 0 -> ERR high one cycle; BUSY = 0; Q unchanged.
- PERIOD = 5, MODE = 1, TICK toggling 1,0 -> DONE interval is 10 CK cycles. Change PERIOD to 2 mid-run -> interval unchanged.
- STOP asserted in the cycle where Q = 0xFF and TICK = 1 -> no DONE; IDLE and Q = 0 next cycle. Repeat the run with RSTN pulled low mid-RUN -> all outputs 0 immediately, without a clock edge.
- CNT_SEQ_PRESCALE_EN defined, PRESC = 4, PERIOD = 2, TICK = 1 -> DONE 8 cycles after Q = L. Undefined -> DONE 2 cycles after Q = L.
